// File: rtl/tp_ntt_pkg.sv
// tp_ntt_pkg: shared constants and index helpers for the TP-point NTT
// stream core.
//   MODE_CT / MODE_GS : per-frame butterfly type (forward / inverse)
//   stages_of(tp)     : number of butterfly stages, log2(tp)
//   lat_of(tp, lat)   : end-to-end latency in enabled cycles
//   twiddle_idx       : twiddle word used by butterfly i of logical stage s
//   perm_idx          : destination lane of lane k under permutation p_s
//   perm_inv          : source lane that p_s moves into lane k
package tp_ntt_pkg;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    function automatic int stages_of(input int tp);
        return $clog2(tp);
    endfunction

    // Each stage is one input register plus a btf_lat-deep butterfly.
    function automatic int lat_of(input int tp, input int btf_lat);
        return $clog2(tp) * (btf_lat + 1);
    endfunction

    function automatic int twiddle_idx(input int tp, input int s, input int i);
        return ((1 << s) - 1) + i / (tp >> (s + 1));
    endfunction

    // Even lane k goes to ((k mod M)/(M/2)) + (k mod M/2) + (k/M)*M with
    // M = tp>>s; its odd partner lands M/2 above that.
    function automatic int perm_idx(input int tp, input int s, input int k);
        int m;
        int ke;
        int dst;
        m   = tp >> s;
        ke  = k - (k % 2);
        dst = ((ke % m) / (m / 2)) + (ke % (m / 2)) + (ke / m) * m;
        if ((k % 2) != 0) dst = dst + m / 2;
        return dst;
    endfunction

    function automatic int perm_inv(input int tp, input int s, input int k);
        int r;
        r = 0;
        for (int j = 0; j < tp; j++) begin
            if (perm_idx(tp, s, j) == k) r = j;
        end
        return r;
    endfunction

endpackage

// File: rtl/tp_btf_ce.sv
// tp_btf_ce: one modular butterfly with selectable type and fixed latency.
//   clk, rst (async, active-low), en (clock enable: 0 holds every register)
//   mode : MODE_CT -> E = a + w*b, O = a - w*b
//          MODE_GS -> E = a + b,   O = (a - b)*w      (all mod q)
//   q, w, a, b : operands, a, b, w < q
//   e, o       : results in [0, q), BTF_LAT enabled cycles after the operands
// The arithmetic is combinational and followed by a BTF_LAT-deep register
// chain so that retiming can spread the multiplier/reduction over it.
module tp_btf_ce
    import tp_ntt_pkg::*;
#(
    parameter int LOGQ    = 32,
    parameter int BTF_LAT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [LOGQ-1:0] q,
    input  logic [LOGQ-1:0] w,
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    output logic [LOGQ-1:0] e,
    output logic [LOGQ-1:0] o
);

    function automatic logic [LOGQ-1:0] add_mod(input logic [LOGQ-1:0] x, y, m);
        logic [LOGQ:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] x, y, m);
        logic [LOGQ:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return d[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] mul_mod(input logic [LOGQ-1:0] x, y, m);
        logic [2*LOGQ-1:0] p;
        logic [2*LOGQ-1:0] r;
        p = {{LOGQ{1'b0}}, x} * {{LOGQ{1'b0}}, y};
        r = p % {{LOGQ{1'b0}}, m};
        return r[LOGQ-1:0];
    endfunction

    logic [LOGQ-1:0] wb;
    logic [LOGQ-1:0] dab;
    logic [LOGQ-1:0] e_c;
    logic [LOGQ-1:0] o_c;
    logic [LOGQ-1:0] e_pipe [BTF_LAT];
    logic [LOGQ-1:0] o_pipe [BTF_LAT];

    always_comb begin
        wb  = mul_mod(w, b, q);
        dab = sub_mod(a, b, q);
        if (mode == MODE_CT) begin
            e_c = add_mod(a, wb, q);
            o_c = sub_mod(a, wb, q);
        end else begin
            e_c = add_mod(a, b, q);
            o_c = mul_mod(dab, w, q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < BTF_LAT; j++) begin
                e_pipe[j] <= '0;
                o_pipe[j] <= '0;
            end
        end else if (en) begin
            e_pipe[0] <= e_c;
            o_pipe[0] <= o_c;
            for (int j = 1; j < BTF_LAT; j++) begin
                e_pipe[j] <= e_pipe[j-1];
                o_pipe[j] <= o_pipe[j-1];
            end
        end
    end

    assign e = e_pipe[BTF_LAT-1];
    assign o = o_pipe[BTF_LAT-1];

endmodule

// File: rtl/tp_ntt_stream_core.sv
// tp_ntt_stream_core: fully unrolled TP-point NTT/INTT, one frame per
// enabled cycle, log2(TP) stages of TP/2 butterflies.
//   clk, rst (async, active-low)
//   en        : pipeline advance; 0 freezes every register
//   in_valid  : frame present; mode 0 = forward CT, 1 = inverse GS
//   q_in      : per-frame odd modulus
//   NTT_in    : TP coefficients, lane 0 in the MSB field
//   W_in      : TP-1 twiddles, word 0 in the MSB field
//   out_valid, out_mode, NTT_out : registered finished frame
//   busy      : some valid frame is still inside the pipeline
// Flow control: there is no backpressure. A frame is taken on every rising
// edge with en=1 and in_valid=1 and is presented with out_valid exactly L
// enabled edges later; while en=0 everything, outputs included, holds.
module tp_ntt_stream_core
    import tp_ntt_pkg::*;
#(
    parameter int TP      = 32,
    parameter int LOGQ    = 32,
    parameter int BTF_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic                   mode,
    input  logic [LOGQ-1:0]        q_in,
    input  logic [LOGQ*TP-1:0]     NTT_in,
    input  logic [LOGQ*(TP-1)-1:0] W_in,
    output logic                   out_valid,
    output logic                   out_mode,
    output logic [LOGQ*TP-1:0]     NTT_out,
    output logic                   busy
);

    localparam int STAGES = stages_of(TP);
    localparam int L      = lat_of(TP, BTF_LAT);
    localparam int D      = BTF_LAT + 1;
    localparam int NW     = TP - 1;

    typedef logic [LOGQ-1:0] word_t;

    // Side pipeline travelling with the data. Stage k reads its operands at
    // index k*D (its input register) and its permutation mode at k*D+BTF_LAT,
    // which lines up with the butterfly outputs of that stage.
    logic  valid_pipe [L];
    logic  mode_pipe  [L];
    word_t q_pipe     [L];
    word_t w_pipe     [L][NW];

    word_t din  [STAGES][TP];
    word_t bout [STAGES][TP];
    word_t nxt  [STAGES][TP];

    for (genvar j = 0; j < TP; j++) begin : g_in_lane
        assign nxt[0][j] = NTT_in[LOGQ*(TP-j)-1 -: LOGQ];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        for (genvar i = 0; i < TP/2; i++) begin : g_btf
            // Physical stage k is logical stage k forward, STAGES-1-k inverse.
            localparam int TF = twiddle_idx(TP, k, i);
            localparam int TI = twiddle_idx(TP, STAGES - 1 - k, i);
            word_t w_sel;
            assign w_sel = (mode_pipe[k*D] == MODE_GS) ? w_pipe[k*D][TI] : w_pipe[k*D][TF];
            tp_btf_ce #(
                .LOGQ    (LOGQ),
                .BTF_LAT (BTF_LAT)
            ) u_btf (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .mode (mode_pipe[k*D]),
                .q    (q_pipe[k*D]),
                .w    (w_sel),
                .a    (din[k][2*i]),
                .b    (din[k][2*i+1]),
                .e    (bout[k][2*i]),
                .o    (bout[k][2*i+1])
            );
        end
    end

    // Between physical stages k and k+1: forward applies p_k (lane m goes to
    // p_k(m)), inverse applies p_(STAGES-2-k)^-1 (lane j takes from p(j)).
    for (genvar k = 0; k + 1 < STAGES; k++) begin : g_perm
        for (genvar j = 0; j < TP; j++) begin : g_lane
            localparam int SRC_F = perm_inv(TP, k, j);
            localparam int SRC_I = perm_idx(TP, STAGES - 2 - k, j);
            assign nxt[k+1][j] = (mode_pipe[k*D + BTF_LAT] == MODE_GS) ?
                                 bout[k][SRC_I] : bout[k][SRC_F];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < TP; j++) din[k][j] <= '0;
            end
            for (int l = 0; l < L; l++) begin
                valid_pipe[l] <= 1'b0;
                mode_pipe[l]  <= 1'b0;
                q_pipe[l]     <= '0;
                for (int t = 0; t < NW; t++) w_pipe[l][t] <= '0;
            end
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            NTT_out   <= '0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < TP; j++) din[k][j] <= nxt[k][j];
            end
            valid_pipe[0] <= in_valid;
            mode_pipe[0]  <= mode;
            q_pipe[0]     <= q_in;
            for (int t = 0; t < NW; t++) w_pipe[0][t] <= W_in[LOGQ*(NW-t)-1 -: LOGQ];
            for (int l = 1; l < L; l++) begin
                valid_pipe[l] <= valid_pipe[l-1];
                mode_pipe[l]  <= mode_pipe[l-1];
                q_pipe[l]     <= q_pipe[l-1];
                for (int t = 0; t < NW; t++) w_pipe[l][t] <= w_pipe[l-1][t];
            end
            out_valid <= valid_pipe[L-1];
            out_mode  <= mode_pipe[L-1];
            for (int j = 0; j < TP; j++) NTT_out[LOGQ*(TP-j)-1 -: LOGQ] <= bout[STAGES-1][j];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int l = 0; l < L; l++) busy = busy | valid_pipe[l];
    end

endmodule
